i2s_tx_sequencer: RTL and testbench
===================================

I2S_TX_SEQUENCER -- requirements
Module: i2s_tx_sequencer

Interface
REQ-001 SHALL have parameter W, default 24, meaning sample data width in bits; legal range 1 to SLOT.
REQ-002 SHALL have parameter SLOT, default 32, meaning bit-clock cycles per channel slot (half lr_clk period).
REQ-003 SHALL have port clk, input, 1 bit: the single clock (bit clock); all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port lr_clk, input, 1 bit: word select, synchronous to clk; 0 = left slot, 1 = right slot.
REQ-006 SHALL have port s_valid, input, 1 bit: a stereo sample pair is offered.
REQ-007 SHALL have port s_left, input, W bits: left sample, two's complement.
REQ-008 SHALL have port s_right, input, W bits: right sample, two's complement.
REQ-009 SHALL have port s_ready, output, 1 bit: the pair is accepted this cycle when s_valid is also high.
REQ-010 SHALL have port sum_res, output, 1 bit: serial data bit to mux_shift, MSB first.
REQ-011 SHALL have port last_shift, output, 1 bit: last bit of the current slot, to mux_shift.
REQ-012 SHALL have port chan, output, 1 bit: channel of the current slot; 0 = left, 1 = right.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when no pair is available at a left-slot start.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a slot ends before SLOT bits.

Function
REQ-015 SHALL register lr_clk into lr_q; an edge is detected in any cycle where lr_clk != lr_q. A falling edge (lr_clk = 0) starts a left slot; a rising edge (lr_clk = 1) starts a right slot.
REQ-016 SHALL implement the states IDLE, LEFT and RIGHT:
  - IDLE to LEFT on a falling edge.
  - LEFT to RIGHT on a rising edge.
  - RIGHT to LEFT on a falling edge.
  - Rising edges in IDLE are ignored.
REQ-017 SHALL drive s_ready combinationally high exactly in cycles where a falling edge is detected; it is low in every other cycle.
REQ-018 On a falling edge with s_valid = 1, SHALL load s_left into the shift register and store s_right in a holding register.
REQ-019 On a falling edge with s_valid = 0, SHALL load zero into the shift register and the holding register, and pulse underrun on the next cycle.
REQ-020 On a rising edge in state LEFT, SHALL load the holding register into the shift register.
REQ-021 SHALL clear the bit counter on every slot-start edge; the counter then increments each cycle and saturates at SLOT-1.
REQ-022 SHALL drive sum_res as a registered output:
  - After the clock edge that loads a word (k = 0), sum_res = word[W-1].
  - After edge k, for k < W, sum_res = word[W-1-k].
  - For k >= W, sum_res = 0 (zero padding).
  - In IDLE, sum_res = 0.
REQ-023 SHALL assert last_shift (registered) for exactly one cycle, when the counter reaches SLOT-1; it is never asserted in IDLE.
REQ-024 When a slot runs longer than SLOT cycles, SHALL keep sum_res = 0 and SHALL NOT assert last_shift again before the next edge.
REQ-025 When an edge arrives while the counter is below SLOT-1 (short slot), SHALL start the new slot normally and pulse frame_err on the next cycle; last_shift is not emitted for the truncated slot.
REQ-026 SHALL update chan on the cycle after each slot-start edge, to 0 for left and 1 for right.
REQ-027 SHALL let a rising edge seen in IDLE leave the holding register unchanged.

Reset
REQ-028 While rst = 1, SHALL hold sum_res, last_shift, underrun, frame_err and chan at 0, with state = IDLE, lr_q = 0, counter = 0, shift register = 0 and holding register = 0.
REQ-029 SHALL give rst priority over any edge detected in the same cycle; a pair offered in that cycle is not accepted, and s_ready = 0 while rst = 1.
REQ-030 When rst is asserted mid-slot, SHALL abort the slot immediately; after release the block waits in IDLE for the next falling edge.

Verification
REQ-031 SHALL be checked with this scenario: W=24, SLOT=32, lr_clk toggling every 32 clk cycles, s_left=24'hA5F00F, s_right=24'h123456, s_valid held high.
  - Required response: the left slot serialises A5F00F MSB first, then 8 zeros; the right slot serialises 123456.
  - Required response: last_shift pulses at counts 31 of each slot.
  - Required response: chan alternates 0, 1.
REQ-032 SHALL be checked with this scenario: s_valid = 0 at a falling edge.
  - Required response: underrun = 1 for one cycle; 64 zero bits are sent; s_ready is seen high for that single cycle only.
REQ-033 SHALL be checked with this scenario: lr_clk half-period reduced to 20 cycles.
  - Required response: frame_err pulses after each edge; last_shift is never asserted; data bits 0 to 19 are correct and truncated after that.
REQ-034 SHALL be checked with this scenario: lr_clk half-period extended to 40 cycles.
  - Required response: last_shift is asserted once per slot, at count 31; sum_res = 0 for counts 24 to 39; frame_err = 0.
REQ-035 SHALL be checked with this scenario: rst pulsed for 2 cycles at count 10 of a right slot.
  - Required response: sum_res = 0 and last_shift = 0 immediately; the next rising edge is ignored; output resumes at the following falling edge.
REQ-036 SHALL be checked with this scenario: rst released with lr_clk = 1.
  - Required response: no output until lr_clk falls; the first slot is left with chan = 0.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: turns stereo sample pairs into an MSB-first serial
// stream framed by lr_clk, with slot-end, underrun and short-slot flags.
//
// state | meaning
// IDLE  | after reset, waiting for the first lr_clk falling edge
// LEFT  | serialising the left word
// RIGHT | serialising the right word (taken from the holding register)
module i2s_tx_sequencer #(
  parameter int W    = 24,
  parameter int SLOT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lr_clk,
  input  logic         s_valid,
  input  logic [W-1:0] s_left,
  input  logic [W-1:0] s_right,
  output logic         s_ready,
  output logic         sum_res,
  output logic         last_shift,
  output logic         chan,
  output logic         underrun,
  output logic         frame_err
);

  localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(SLOT - 2);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_lr_q;
  logic           w_fall, w_rise, w_start;
  logic [W-1:0]   w_word;
  logic [W-1:0]   r_shift, r_hold;
  logic [CW-1:0]  r_cnt;
  logic           r_sum, r_last, r_chan, r_underrun, r_frame_err;

  always_comb begin
    w_fall      = (lr_clk != r_lr_q) && !lr_clk;
    w_rise      = (lr_clk != r_lr_q) && lr_clk;
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_word      = r_hold;
    case (r_state)
      IDLE:  if (w_fall) begin w_state_nxt = LEFT;  w_start = 1'b1; end
      LEFT:  if (w_rise) begin w_state_nxt = RIGHT; w_start = 1'b1; end
      RIGHT: if (w_fall) begin w_state_nxt = LEFT;  w_start = 1'b1; end
      default: w_state_nxt = IDLE;
    endcase
    if (w_fall) w_word = s_valid ? s_left : '0;
  end

  assign s_ready = w_fall && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lr_q      <= 1'b0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_sum       <= 1'b0;
      r_last      <= 1'b0;
      r_chan      <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_lr_q      <= lr_clk;
      r_underrun  <= w_fall && !s_valid;
      r_frame_err <= w_start && (r_state != IDLE) && (r_cnt != CNT_MAX);
      if (w_fall) r_hold <= s_valid ? s_right : '0;
      if (w_start) begin
        r_shift <= w_word << 1;
        r_sum   <= w_word[W-1];
        r_cnt   <= '0;
        r_chan  <= w_rise;
        r_last  <= 1'b0;
      end else if (r_state == IDLE) begin
        r_sum  <= 1'b0;
        r_last <= 1'b0;
      end else begin
        // Zeros shift in behind the word, which gives the slot padding for free.
        r_shift <= r_shift << 1;
        r_sum   <= r_shift[W-1];
        r_last  <= (r_cnt == CNT_PRE);
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum_res    = r_sum;
  assign last_shift = r_last;
  assign chan       = r_chan;
  assign underrun   = r_underrun;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer: directed framing scenarios plus
// randomized slot lengths and data, compared cycle by cycle with a slot model.
module tb_i2s_tx_sequencer;

  localparam int W    = 24;
  localparam int SLOT = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lr_clk = 1'b0;
  logic         s_valid = 1'b1;
  logic [W-1:0] s_left = '0;
  logic [W-1:0] s_right = '0;
  logic         s_ready, sum_res, last_shift, chan, underrun, frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: slot-level view (active flag, cycles since slot start, word).
  bit           m_prev;
  bit           m_active;
  int           m_k;
  logic [W-1:0] m_word, m_hold;
  bit           m_chan;
  bit           e_under, e_ferr;

  always #5 clk = ~clk;

  i2s_tx_sequencer #(.W(W), .SLOT(SLOT)) dut (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .s_valid(s_valid),
    .s_left(s_left), .s_right(s_right), .s_ready(s_ready),
    .sum_res(sum_res), .last_shift(last_shift), .chan(chan),
    .underrun(underrun), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_k = 0; m_word = '0; m_hold = '0;
    m_chan = 0; e_under = 0; e_ferr = 0;
  endtask

  task automatic model_clock();
    bit fall, rise;
    fall = (lr_clk != m_prev) && !lr_clk;
    rise = (lr_clk != m_prev) && lr_clk;
    e_under = 0;
    e_ferr  = 0;
    if (rst) begin
      model_reset();
      return;
    end
    m_prev = lr_clk;
    if (fall) begin
      e_under  = !s_valid;
      e_ferr   = m_active && (m_k < SLOT - 1);
      m_word   = s_valid ? s_left : '0;
      m_hold   = s_valid ? s_right : '0;
      m_k      = 0;
      m_active = 1;
      m_chan   = 0;
    end else if (rise && m_active && !m_chan) begin
      e_ferr = m_k < SLOT - 1;
      m_word = m_hold;
      m_k    = 0;
      m_chan = 1;
    end else if (m_active) begin
      m_k++;
    end
  endtask

  // One clock: check the combinational ready, advance, then check registered outputs.
  task automatic step();
    bit exp_sum, exp_last;
    #1;
    chk("s_ready", s_ready, ((lr_clk != m_prev) && !lr_clk && !rst));
    model_clock();
    @(posedge clk);
    #1;
    exp_sum  = m_active && (m_k < W) ? m_word[W-1-m_k] : 1'b0;
    exp_last = m_active && (m_k == SLOT - 1);
    chk("sum_res", sum_res, exp_sum);
    chk("last_shift", last_shift, exp_last);
    chk("chan", chan, m_chan);
    chk("underrun", underrun, e_under);
    chk("frame_err", frame_err, e_ferr);
  endtask

  task automatic slot(input bit lr, input int n);
    lr_clk = lr;
    repeat (n) step();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    lr_clk = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // Released with lr_clk high: the rising edge seen in IDLE must be ignored.
    slot(1, 6);

    s_left  = 24'hA5F00F;
    s_right = 24'h123456;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot(0, SLOT);
      slot(1, SLOT);
    end

    // Underrun: no pair offered at the left-slot start.
    s_valid = 1'b0;
    slot(0, SLOT);
    slot(1, SLOT);
    s_valid = 1'b1;
    slot(0, SLOT);
    slot(1, SLOT);

    // Short slots.
    for (int i = 0; i < 3; i++) begin
      slot(0, 20);
      slot(1, 20);
    end
    slot(0, SLOT);
    slot(1, SLOT);

    // Long slots.
    for (int i = 0; i < 3; i++) begin
      slot(0, 40);
      slot(1, 40);
    end

    // Reset pulse at count 10 of a right slot.
    slot(0, SLOT);
    slot(1, 11);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    slot(1, SLOT - 13);
    slot(1, 5);
    slot(0, SLOT);
    slot(1, SLOT);

    // Randomized slot lengths, data and sample availability.
    for (int i = 0; i < 40; i++) begin
      s_left  = W'($urandom);
      s_right = W'($urandom);
      s_valid = ($urandom_range(0, 7) != 0);
      slot(0, $urandom_range(16, 44));
      s_valid = $urandom_range(0, 1);
      slot(1, $urandom_range(16, 44));
    end
    slot(0, SLOT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
